// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register dump reader and the core-side port mux
// that lends it a register-file read port.
//   dump_state_t : walker FSM state encoding
//   reg_num()    : number of registers walked for a given address width
package reg_dump_reader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    READ = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } dump_state_t;

  function automatic int unsigned reg_num(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_dump_reader.sv
// Register dump reader: on a start pulse, walks every register through a
// borrowed register-file read port and streams (index, value) beats out on a
// valid/ready interface.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               one-cycle pulse, accepted only when idle
//   busy, done          busy from accepted start through the done pulse
//   dump_req, dump_gnt  request/grant for the shared read port
//   rf_raddr, rf_rdata  read port (combinational read, same-cycle data)
//   out_valid/ready     beat handshake
//   out_idx/data/last   beat payload; last marks index REG_NUM-1
//
// state | meaning
// IDLE  | waiting for start
// REQ   | requesting the read port, waiting for grant
// READ  | driving rf_raddr=idx; capture beat if still granted, else re-request
// SEND  | beat held on output until handshake
// DONE  | one-cycle done pulse
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              dump_req,
  input  logic              dump_gnt,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int REG_NUM = int'(reg_num(ADDR_W));
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dump_req_q, dump_req_d;
  logic [ADDR_W-1:0] rf_raddr_q, rf_raddr_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (dump_gnt) state_d = READ;
      end
      READ: begin
        // Grant can vanish in the very cycle we read; only capture while held.
        if (dump_gnt) begin
          out_data_d  = rf_rdata;
          out_idx_d   = idx_q;
          out_last_d  = (idx_q == LAST_IDX);
          out_valid_d = 1'b1;
          state_d     = SEND;
        end else begin
          state_d = REQ;
        end
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered outputs are derived from the next state so they line up
    // with the state they describe.
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    dump_req_d = (state_d == REQ) || (state_d == READ);
    rf_raddr_d = (state_d == READ) ? idx_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dump_req_q  <= 1'b0;
      rf_raddr_q  <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dump_req_q  <= dump_req_d;
      rf_raddr_q  <= rf_raddr_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dump_req  = dump_req_q;
  assign rf_raddr  = rf_raddr_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: a 32-register instance driven through directed
// scenarios with a beat scoreboard, plus an 8-register instance.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, dump_req, dump_gnt;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        out_valid, out_ready, out_last;
  logic [4:0]  out_idx;
  logic [31:0] out_data;

  logic        start8, busy8, done8, req8, out_valid8, out_last8;
  logic        gnt8, ready8;
  logic [2:0]  raddr8, out_idx8;
  logic [31:0] rdata8, out_data8;

  logic [31:0] regs [32];
  logic [31:0] regs8 [8];

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;
  beat_t sb[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  int start_cyc = 0;
  int exp_gap = -1;
  int done8_cnt = 0;
  int beats8 = 0;
  int start8_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rf_rdata = regs[rf_raddr];
  assign rdata8   = regs8[raddr8];

  reg_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .dump_req(dump_req), .dump_gnt(dump_gnt), .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data), .out_last(out_last)
  );

  reg_dump_reader #(.ADDR_W(3), .DATA_W(32)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
    .dump_req(req8), .dump_gnt(gnt8), .rf_raddr(raddr8),
    .rf_rdata(rdata8), .out_valid(out_valid8), .out_ready(ready8),
    .out_idx(out_idx8), .out_data(out_data8), .out_last(out_last8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_regs(input logic [31:0] base);
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : base + 32'(i);
  endtask

  // Expected beats: index 0 always reads zero, others base+i.
  task automatic push_dump(input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < 32; i++) begin
      b.idx  = 5'(i);
      b.data = (i == 0) ? 32'h0 : base + 32'(i);
      b.last = (i == 31);
      sb.push_back(b);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_read(input logic [4:0] idx);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dump_req && rf_raddr == idx) && n < 1000);
    if (n >= 1000) chk("wait_read_timeout", 64'(idx), 64'hFFFF);
  endtask

  task automatic wait_beat(input logic [4:0] idx);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_idx == idx) && n < 1000);
    if (n >= 1000) chk("wait_beat_timeout", 64'(idx), 64'hFFFF);
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk({name, "_done_timeout"}, 64'(done_cnt), 64'(d0 + 1));
    repeat (3) @(negedge clk);
    chk({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard monitor for the 32-register instance.
  initial begin
    logic  stalled = 1'b0;
    beat_t held;
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_idx",   64'(out_idx),   64'(held.idx));
          chk("stall_data",  64'(out_data),  64'(held.data));
          chk("stall_last",  64'(out_last),  64'(held.last));
        end
        if (out_valid && out_ready) begin
          stalled = 1'b0;
          if (sb.size() == 0) begin
            chk("unexpected_beat", 64'(out_idx), 64'hFFFF);
          end else begin
            e = sb.pop_front();
            chk("beat_idx",  64'(out_idx),  64'(e.idx));
            chk("beat_data", 64'(out_data), 64'(e.data));
            chk("beat_last", 64'(out_last), 64'(e.last));
          end
        end else if (out_valid) begin
          stalled   = 1'b1;
          held.idx  = out_idx;
          held.data = out_data;
          held.last = out_last;
          stall_cnt++;
        end else begin
          stalled = 1'b0;
        end
        if (done) begin
          done_cnt++;
          chk("done_busy", 64'(busy), 64'd1);
          if (exp_gap >= 0) chk("done_latency", 64'(cyc - start_cyc), 64'(exp_gap));
        end
      end
    end
  end

  // Monitor for the 8-register instance (always granted and ready).
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid8) begin
          chk("b8_idx",  64'(out_idx8),  64'(beats8));
          chk("b8_data", 64'(out_data8), (beats8 == 0) ? 64'h0 : 64'h5A00_0000 + 64'(beats8));
          chk("b8_last", 64'(out_last8), 64'(beats8 == 7));
          beats8++;
        end
        if (done8) begin
          done8_cnt++;
          chk("b8_done_latency", 64'(cyc - start8_cyc), 64'd25);
        end
      end
    end
  end

  initial begin
    int d0;
    int n;
    rst = 1'b1; start = 1'b0; dump_gnt = 1'b1; out_ready = 1'b1;
    start8 = 1'b0; gnt8 = 1'b1; ready8 = 1'b1;
    for (int i = 0; i < 8; i++) regs8[i] = (i == 0) ? 32'h0 : 32'h5A00_0000 + 32'(i);
    load_regs(32'hA500_0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_req", 64'(dump_req), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_idx_data_raddr", {27'd0, out_idx, out_data}, 64'd0);
    chk("rst_raddr", 64'(rf_raddr), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: full dump, grant and ready held high
    exp_gap = 97;
    push_dump(32'hA500_0000);
    pulse_start();
    wait_done("t1");

    // 2: sink stalls on beat 7
    load_regs(32'h5A5A_0000);
    exp_gap = -1;
    push_dump(32'h5A5A_0000);
    pulse_start();
    wait_read(5'd7);
    stall_cnt = 0;
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    chk("t2_stall_cycles", 64'(stall_cnt), 64'd5);
    wait_done("t2");

    // 3: grant lost in READ of idx 12
    load_regs(32'h1234_0000);
    push_dump(32'h1234_0000);
    pulse_start();
    wait_beat(5'd11);
    @(posedge clk);
    @(posedge clk); #1 dump_gnt = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t3_req_held", 64'(dump_req), 64'd1);
      chk("t3_no_beat", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1 dump_gnt = 1'b1;
    wait_done("t3");

    // 4: second start while busy is ignored
    load_regs(32'hFFFF_0000);
    exp_gap = 97;
    push_dump(32'hFFFF_0000);
    pulse_start();
    wait_beat(5'd3);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t4");

    // 5: reset during SEND of idx 20, then a fresh dump
    load_regs(32'hA500_0000);
    exp_gap = -1;
    push_dump(32'hA500_0000);
    pulse_start();
    wait_read(5'd20);
    @(posedge clk); #1 out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t5_send_valid", 64'(out_valid), 64'd1);
    d0 = done_cnt;
    @(negedge clk);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_req", 64'(dump_req), 64'd0);
    chk("t5_rst_payload", {26'd0, out_last, out_idx, out_data}, 64'd0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_no_done", 64'(done_cnt), 64'(d0));
    exp_gap = 97;
    push_dump(32'hA500_0000);
    pulse_start();
    wait_done("t5");

    // 6: 8-register build
    @(posedge clk); #1 start8 = 1'b1; start8_cyc = cyc;
    @(posedge clk); #1 start8 = 1'b0;
    n = 0;
    while (done8_cnt == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_done8", 64'(done8_cnt), 64'd1);
    chk("t6_beats8", 64'(beats8), 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
